// File: rtl/vid_timing_gen_if.sv
// Pixel-domain video timing bundle: enable in, sync/DE/coordinates/pattern out.
// master = timing generator, slave = downstream consumer (renderer / output stage).
interface vid_timing_gen_if;
  logic        i_en;
  logic        o_hsync;
  logic        o_vsync;
  logic        o_de;
  logic [10:0] o_x;
  logic [10:0] o_y;
  logic        o_line_start;
  logic        o_frame_start;
  logic [23:0] o_rgb;

  modport master (
    input  i_en,
    output o_hsync,
    output o_vsync,
    output o_de,
    output o_x,
    output o_y,
    output o_line_start,
    output o_frame_start,
    output o_rgb
  );

  modport slave (
    output i_en,
    input  o_hsync,
    input  o_vsync,
    input  o_de,
    input  o_x,
    input  o_y,
    input  o_line_start,
    input  o_frame_start,
    input  o_rgb
  );
endinterface

// File: rtl/vid_timing_gen.sv
// Raster timing generator: h/v counters with registered sync, DE, coordinates and pulses.
// Optional colour-bar test pattern on rgb when VID_TIMING_PATTERN_EN is defined.
module vid_timing_gen #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 40,
  parameter int unsigned H_SYNC   = 128,
  parameter int unsigned H_BP     = 88,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned V_FP     = 1,
  parameter int unsigned V_SYNC   = 4,
  parameter int unsigned V_BP     = 23,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1
) (
  input  logic              i_clkin,
  input  logic              i_rst_n,
  vid_timing_gen_if.master  io_vid
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_ACT_W    = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_ACT_W    = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);

  logic [10:0] r_h_cnt, r_v_cnt;
  logic [10:0] w_h_cnt_nxt, w_v_cnt_nxt;

  logic        r_hsync, r_vsync, r_de, r_line_start, r_frame_start;
  logic [10:0] r_x, r_y;
  logic        w_hsync_nxt, w_vsync_nxt, w_de_nxt, w_line_start_nxt, w_frame_start_nxt;
  logic [10:0] w_x_nxt, w_y_nxt;

  logic w_active_h, w_active_v, w_hs_on, w_vs_on, w_h_last, w_v_last, w_de_now;

  // Decodes are taken from the current counter position; outputs land one clock later.
  assign w_active_h = r_h_cnt < H_ACT_W;
  assign w_active_v = r_v_cnt < V_ACT_W;
  assign w_hs_on    = (r_h_cnt >= H_SYNC_BEG) && (r_h_cnt < H_SYNC_END);
  assign w_vs_on    = (r_v_cnt >= V_SYNC_BEG) && (r_v_cnt < V_SYNC_END);
  assign w_h_last   = r_h_cnt == H_LAST;
  assign w_v_last   = r_v_cnt == V_LAST;
  assign w_de_now   = w_active_h && w_active_v;

  always_comb begin
    w_h_cnt_nxt = r_h_cnt;
    w_v_cnt_nxt = r_v_cnt;
    if (io_vid.i_en) begin
      if (w_h_last) begin
        w_h_cnt_nxt = '0;
        w_v_cnt_nxt = w_v_last ? '0 : r_v_cnt + 11'd1;
      end else begin
        w_h_cnt_nxt = r_h_cnt + 11'd1;
      end
    end
  end

  // With en low the levels hold and the pulses drop to zero.
  always_comb begin
    w_hsync_nxt       = r_hsync;
    w_vsync_nxt       = r_vsync;
    w_de_nxt          = r_de;
    w_x_nxt           = r_x;
    w_y_nxt           = r_y;
    w_line_start_nxt  = 1'b0;
    w_frame_start_nxt = 1'b0;
    if (io_vid.i_en) begin
      w_hsync_nxt       = w_hs_on ? HS_POL : ~HS_POL;
      w_vsync_nxt       = w_vs_on ? VS_POL : ~VS_POL;
      w_de_nxt          = w_de_now;
      w_line_start_nxt  = (r_h_cnt == 11'd0) && w_active_v;
      w_frame_start_nxt = (r_h_cnt == 11'd0) && (r_v_cnt == 11'd0);
      if (w_de_now) begin
        w_x_nxt = r_h_cnt;
        w_y_nxt = r_v_cnt;
      end
    end
  end

  always_ff @(posedge i_clkin) begin
    if (!i_rst_n) begin
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_hsync       <= ~HS_POL;
      r_vsync       <= ~VS_POL;
      r_de          <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_h_cnt       <= w_h_cnt_nxt;
      r_v_cnt       <= w_v_cnt_nxt;
      r_hsync       <= w_hsync_nxt;
      r_vsync       <= w_vsync_nxt;
      r_de          <= w_de_nxt;
      r_x           <= w_x_nxt;
      r_y           <= w_y_nxt;
      r_line_start  <= w_line_start_nxt;
      r_frame_start <= w_frame_start_nxt;
    end
  end

  assign io_vid.o_hsync       = r_hsync;
  assign io_vid.o_vsync       = r_vsync;
  assign io_vid.o_de          = r_de;
  assign io_vid.o_x           = r_x;
  assign io_vid.o_y           = r_y;
  assign io_vid.o_line_start  = r_line_start;
  assign io_vid.o_frame_start = r_frame_start;

`ifdef VID_TIMING_PATTERN_EN
  localparam logic [10:0] BAR_W = 11'(H_ACTIVE / 8);

  // r_bar_pix/r_bar_idx describe the pixel at the current h_cnt; zeroed at line wrap.
  logic [10:0] r_bar_pix, w_bar_pix_nxt;
  logic [2:0]  r_bar_idx, w_bar_idx_nxt;
  logic [23:0] r_rgb, w_rgb_nxt, w_bar_rgb;

  always_comb begin
    w_bar_pix_nxt = r_bar_pix;
    w_bar_idx_nxt = r_bar_idx;
    if (io_vid.i_en) begin
      if (w_h_last) begin
        w_bar_pix_nxt = '0;
        w_bar_idx_nxt = '0;
      end else if (w_active_h) begin
        if (r_bar_pix == BAR_W - 11'd1) begin
          w_bar_pix_nxt = '0;
          w_bar_idx_nxt = r_bar_idx + 3'd1;
        end else begin
          w_bar_pix_nxt = r_bar_pix + 11'd1;
        end
      end
    end
  end

  always_comb begin
    case (r_bar_idx)
      3'd0:    w_bar_rgb = 24'hFFFFFF;
      3'd1:    w_bar_rgb = 24'hFFFF00;
      3'd2:    w_bar_rgb = 24'h00FFFF;
      3'd3:    w_bar_rgb = 24'h00FF00;
      3'd4:    w_bar_rgb = 24'hFF00FF;
      3'd5:    w_bar_rgb = 24'hFF0000;
      3'd6:    w_bar_rgb = 24'h0000FF;
      default: w_bar_rgb = 24'h000000;
    endcase
  end

  always_comb begin
    w_rgb_nxt = 24'h0;
    if (io_vid.i_en && w_de_now) begin
      w_rgb_nxt = w_bar_rgb;
    end
  end

  always_ff @(posedge i_clkin) begin
    if (!i_rst_n) begin
      r_bar_pix <= '0;
      r_bar_idx <= '0;
      r_rgb     <= '0;
    end else begin
      r_bar_pix <= w_bar_pix_nxt;
      r_bar_idx <= w_bar_idx_nxt;
      r_rgb     <= w_rgb_nxt;
    end
  end

  assign io_vid.o_rgb = r_rgb;
`else
  assign io_vid.o_rgb = 24'h0;
`endif

endmodule
